// File: rtl/ex_div_unit_pkg.sv
// Shared definitions for the EX-stage RV32M divider: op encodings, FSM states, width default.
package ex_div_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct3[1:0] of the M-extension divide group
  localparam logic [1:0] DIV_OP  = 2'b00;
  localparam logic [1:0] DIVU_OP = 2'b01;
  localparam logic [1:0] REM_OP  = 2'b10;
  localparam logic [1:0] REMU_OP = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One radix-2 restoring iteration: shift {rem,quo} left and trial-subtract the divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem < divisor on entry, so a non-negative difference always fits in XLEN bits
  always_comb begin
    shifted = {rem, quo[XLEN-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[XLEN]) begin
      rem_next = diff[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b1};
    end else begin
      rem_next = shifted[XLEN-1:0];
      quo_next = {quo[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/ex_div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e state, state_next;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem_q, quo_q, dsr_q, result_q;
  logic            q_neg, r_neg, op_rem;

  logic            signed_op, a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs;
  logic            div_zero, overflow, special, accept;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] rem_step, quo_step;
  logic [XLEN-1:0] quo_fix, rem_fix;

  // Handshake: start is taken on a rising edge only in IDLE or DONE and only without kill;
  // busy stays high through CALC and FIX (operands/start ignored meanwhile); done is a
  // one-cycle pulse during which result is valid, and result then holds until the next accept.
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & dividend[XLEN-1];
  assign b_neg     = signed_op & divisor[XLEN-1];
  assign a_abs     = a_neg ? -dividend : dividend;
  assign b_abs     = b_neg ? -divisor : divisor;
  assign div_zero  = (divisor == '0);
  assign overflow  = signed_op && (dividend == MIN_NEG) && (divisor == '1);
  assign special   = div_zero || overflow;
  assign accept    = start && !kill && (state == IDLE || state == DONE);

  always_comb begin
    special_res = '0;
    if (div_zero) special_res = op[1] ? dividend : '1;
    else          special_res = op[1] ? '0 : dividend;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dsr_q),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  assign quo_fix = q_neg ? -quo_q : quo_q;
  assign rem_fix = r_neg ? -rem_q : rem_q;

  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) state_next = special ? DONE : CALC;
          else       state_next = IDLE;
        end
        CALC:    if (cnt == '0) state_next = FIX;
        FIX:     state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      op_rem   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      if (special) begin
        result_q <= special_res;
      end else begin
        rem_q  <= '0;
        quo_q  <= a_abs;
        dsr_q  <= b_abs;
        q_neg  <= a_neg ^ b_neg;
        r_neg  <= a_neg;
        op_rem <= op[1];
        cnt    <= CW'(XLEN - 1);
      end
    end else if (!kill && state == CALC) begin
      rem_q <= rem_step;
      quo_q <= quo_step;
      cnt   <= cnt - 1'b1;
    end else if (!kill && state == FIX) begin
      result_q <= op_rem ? rem_fix : quo_fix;
    end
  end

  assign busy   = (state == CALC) || (state == FIX);
  assign done   = (state == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed corner cases, control scenarios, random ops.
module tb_ex_div_unit;
  import ex_div_unit_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         kill = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done;
  logic [W-1:0] result;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_res = '0;

  ex_div_unit #(.XLEN(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .kill     (kill),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return o[1] ? a : '1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? '0 : a;
    case (o)
      2'b00:   return $signed(a) / $signed(b);
      2'b01:   return a / b;
      2'b10:   return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Issues one request, pushes its expected result, waits (bounded) for done.
  // lat counts edges after the accept edge; busy_cnt counts cycles sampled busy.
  task automatic drive_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp, output int lat, output int busy_cnt, output bit seen);
    @(negedge clk);
    start = 1'b1; op = o; dividend = a; divisor = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    seen = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (result !== '0)  begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_div_latency();
    int lat, bc; bit seen; logic [W-1:0] exp;
    drive_op(DIV_OP, 32'h0000_0064, 32'hFFFF_FFF9, 32'hFFFF_FFF2, lat, bc, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen)        begin errors++; $display("FAIL div_timeout no done within 100 edges"); end
    checks++; if (result !== exp) begin errors++; $display("FAIL div_result got %h exp %h", result, exp); end
    checks++; if (lat != 33)    begin errors++; $display("FAIL div_latency got %0d exp 33", lat); end
    checks++; if (bc != 33)     begin errors++; $display("FAIL div_busy_cycles got %0d exp 33", bc); end
    last_res = exp;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done); end
  endtask

  task automatic test_arith();
    logic [1:0]   ops[3] = '{REM_OP, REMU_OP, DIVU_OP};
    logic [W-1:0] as[3]  = '{32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [W-1:0] bs[3]  = '{32'h0000_0007, 32'h0000_0010, 32'h0000_0010};
    logic [W-1:0] es[3]  = '{32'hFFFF_FFFE, 32'h0000_000F, 32'h0FFF_FFFF};
    for (int i = 0; i < 3; i++) begin
      int lat, bc; bit seen; logic [W-1:0] exp;
      drive_op(ops[i], as[i], bs[i], es[i], lat, bc, seen);
      exp = exp_q.pop_front();
      checks++; if (!seen || result !== exp) begin errors++; $display("FAIL arith_%0d got %h exp %h", i, result, exp); end
      last_res = exp;
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] es[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678};
    for (int i = 0; i < 4; i++) begin
      int lat, bc; bit seen; logic [W-1:0] exp;
      drive_op(2'(i), 32'h1234_5678, '0, es[i], lat, bc, seen);
      exp = exp_q.pop_front();
      checks++; if (!seen || result !== exp) begin errors++; $display("FAIL divzero_op%0d got %h exp %h", i, result, exp); end
      checks++; if (lat != 0)   begin errors++; $display("FAIL divzero_lat_op%0d got %0d exp 0", i, lat); end
      last_res = exp;
    end
  endtask

  // Each request is issued from the DONE cycle of the previous one.
  task automatic test_back_to_back();
    int lat, bc; bit seen; logic [W-1:0] exp;
    drive_op(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, lat, bc, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || result !== exp) begin errors++; $display("FAIL ovf_div got %h exp %h", result, exp); end
    checks++; if (lat != 0) begin errors++; $display("FAIL ovf_div_lat got %0d exp 0", lat); end
    drive_op(REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, lat, bc, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || result !== exp) begin errors++; $display("FAIL ovf_rem_b2b got %h exp %h", result, exp); end
    checks++; if (lat != 0) begin errors++; $display("FAIL ovf_rem_lat got %0d exp 0", lat); end
    drive_op(DIVU_OP, 32'd1000, 32'd7, 32'd142, lat, bc, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || result !== exp) begin errors++; $display("FAIL b2b_divu got %h exp %h", result, exp); end
    checks++; if (lat != 33) begin errors++; $display("FAIL b2b_divu_lat got %0d exp 33", lat); end
    last_res = exp;
  endtask

  task automatic test_kill();
    int seen_done = 0;
    @(negedge clk);
    start = 1'b1; op = DIV_OP; dividend = 32'd5000; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b exp 0", busy); end
    checks++; if (result !== last_res) begin errors++; $display("FAIL kill_result got %h exp %h", result, last_res); end
    repeat (40) begin @(posedge clk); #1; if (done) seen_done++; end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL kill_no_done got %0d pulses exp 0", seen_done); end
  endtask

  task automatic test_kill_in_done();
    int lat, bc, seen_done; bit seen; logic [W-1:0] exp;
    drive_op(REMU_OP, 32'h0000_ABCD, '0, 32'h0000_ABCD, lat, bc, seen);
    exp = exp_q.pop_front();
    checks++; if (!seen || result !== exp) begin errors++; $display("FAIL kd_setup got %h exp %h", result, exp); end
    @(negedge clk);
    kill = 1'b1; start = 1'b1; op = DIVU_OP; dividend = 32'd5; divisor = '0;
    @(posedge clk); #1; kill = 1'b0; start = 1'b0;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL kd_state got done=%b busy=%b exp 0/0", done, busy); end
    checks++; if (result !== exp) begin errors++; $display("FAIL kd_result got %h exp %h", result, exp); end
    seen_done = 0;
    repeat (5) begin @(posedge clk); #1; if (done) seen_done++; end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL kd_no_done got %0d exp 0", seen_done); end
    last_res = exp;
  endtask

  task automatic test_start_ignore();
    int lat; logic [W-1:0] exp;
    @(negedge clk);
    start = 1'b1; op = DIVU_OP; dividend = 32'd1000; divisor = 32'd3;
    exp_q.push_back(32'd333);
    @(posedge clk); #1; start = 1'b0; lat = 0;
    repeat (5) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    start = 1'b1; op = REM_OP; dividend = 32'd7; divisor = '0;
    @(posedge clk); #1; start = 1'b0; lat++;
    dividend = 32'hDEAD_BEEF; divisor = 32'd1;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    exp = exp_q.pop_front();
    checks++; if (!done || result !== exp) begin errors++; $display("FAIL ignore_result got %h exp %h", result, exp); end
    checks++; if (lat != 33) begin errors++; $display("FAIL ignore_lat got %0d exp 33", lat); end
    last_res = exp;
  endtask

  task automatic test_async_reset();
    int seen_done = 0;
    @(negedge clk);
    start = 1'b1; op = REM_OP; dividend = 32'd12345; divisor = 32'd17;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL areset_ctrl got busy=%b done=%b exp 0/0", busy, done); end
    checks++; if (result !== '0) begin errors++; $display("FAIL areset_result got %h exp 0", result); end
    @(negedge clk); reset = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen_done++; end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL areset_no_done got %0d exp 0", seen_done); end
    last_res = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int lat, bc; bit seen; logic [W-1:0] exp;
      logic [1:0] o; logic [W-1:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 20));
        2:       b = -W'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      drive_op(o, a, b, model(o, a, b), lat, bc, seen);
      exp = exp_q.pop_front();
      checks++; if (!seen || result !== exp) begin errors++; $display("FAIL rand_%0d op=%0d a=%h b=%h got %h exp %h", i, o, a, b, result, exp); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_div_latency();
    test_arith();
    test_div_zero();
    test_back_to_back();
    test_kill();
    test_kill_in_done();
    test_start_ignore();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
